// File: rtl/tmds_rx_align_decode.sv
// Per-channel TMDS receiver: finds the bit offset from runs of control symbols,
// barrel-shifts the deserialised stream and decodes 10b symbols to pixel/control data.
module tmds_rx_align_decode #(
  parameter int LOCK_RUN      = 16,
  parameter int SEARCH_CYCLES = 1024,
  parameter int LOSS_CYCLES   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] in_sym,
  output logic [7:0] out_data,
  output logic [1:0] out_ctrl,
  output logic       out_de,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int TMR_W = $clog2((SEARCH_CYCLES > LOSS_CYCLES) ? SEARCH_CYCLES : LOSS_CYCLES);
  localparam int RUN_W = $clog2(LOCK_RUN + 1);

  localparam logic [TMR_W-1:0] SEARCH_LAST = TMR_W'(SEARCH_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOSS_LAST   = TMR_W'(LOSS_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(LOCK_RUN);
  localparam logic [RUN_W-1:0] RUN_PRE     = RUN_W'(LOCK_RUN - 1);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [9:0]       r_prev;
  logic [3:0]       r_offset, w_offset_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [RUN_W-1:0] r_run, w_run_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic [1:0]       r_ctrl, w_ctrl_nxt;
  logic             r_de, w_de_nxt;

  // in_sym[9] can never fall inside a 10-bit slice at offsets 0..9.
  logic [18:0] w_window;
  logic [9:0]  w_sym;
  logic        w_is_ctrl;
  logic [1:0]  w_code;
  logic [7:0]  w_q;
  logic [7:0]  w_dec;
  logic        w_lock_hit;

  assign w_window = {in_sym[8:0], r_prev};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_sym = w_window[9:0];
    case (r_offset)
      4'd1:    w_sym = w_window[10:1];
      4'd2:    w_sym = w_window[11:2];
      4'd3:    w_sym = w_window[12:3];
      4'd4:    w_sym = w_window[13:4];
      4'd5:    w_sym = w_window[14:5];
      4'd6:    w_sym = w_window[15:6];
      4'd7:    w_sym = w_window[16:7];
      4'd8:    w_sym = w_window[17:8];
      4'd9:    w_sym = w_window[18:9];
      default: w_sym = w_window[9:0];
    endcase
  end

  always_comb begin
    w_is_ctrl = 1'b1;
    w_code    = 2'b00;
    case (w_sym)
      10'h354: w_code = 2'b00;
      10'h0AB: w_code = 2'b01;
      10'h154: w_code = 2'b10;
      10'h2AB: w_code = 2'b11;
      default: w_is_ctrl = 1'b0;
    endcase
  end

  // Undo the transmit-side inversion (bit 9) and XOR/XNOR chain (bit 8).
  always_comb begin
    w_q      = w_sym[9] ? ~w_sym[7:0] : w_sym[7:0];
    w_dec    = '0;
    w_dec[0] = w_q[0];
    for (int i = 1; i < 8; i++) begin
      w_dec[i] = w_sym[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
    end
  end

  assign w_lock_hit = w_is_ctrl && (r_run == RUN_PRE);

  always_comb begin
    w_state_nxt  = r_state;
    w_offset_nxt = r_offset;
    w_timer_nxt  = r_timer + TMR_W'(1);
    if (!w_is_ctrl)
      w_run_nxt = '0;
    else if (r_run == RUN_FULL)
      w_run_nxt = r_run;
    else
      w_run_nxt = r_run + RUN_W'(1);

    case (r_state)
      ST_SEARCH: begin
        if (w_lock_hit) begin
          w_state_nxt = ST_LOCKED;
          w_timer_nxt = '0;
        end else if (r_timer == SEARCH_LAST) begin
          w_offset_nxt = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
          w_timer_nxt  = '0;
          w_run_nxt    = '0;
        end
      end
      ST_LOCKED: begin
        // A completed or still-running full control run feeds the watchdog.
        if (w_lock_hit || (r_run == RUN_FULL)) begin
          w_timer_nxt = '0;
        end else if (r_timer == LOSS_LAST) begin
          w_state_nxt = ST_SEARCH;
          w_timer_nxt = '0;
          w_run_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_SEARCH;
    endcase

    w_de_nxt   = 1'b0;
    w_data_nxt = '0;
    w_ctrl_nxt = '0;
    if (w_state_nxt == ST_LOCKED) begin
      if (w_is_ctrl) begin
        w_ctrl_nxt = w_code;
      end else begin
        w_de_nxt   = 1'b1;
        w_data_nxt = w_dec;
        w_ctrl_nxt = r_ctrl;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_SEARCH;
      r_prev   <= '0;
      r_offset <= '0;
      r_timer  <= '0;
      r_run    <= '0;
      r_data   <= '0;
      r_ctrl   <= '0;
      r_de     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_prev   <= in_sym;
      r_offset <= w_offset_nxt;
      r_timer  <= w_timer_nxt;
      r_run    <= w_run_nxt;
      r_data   <= w_data_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_de     <= w_de_nxt;
    end
  end

  assign out_data = r_data;
  assign out_ctrl = r_ctrl;
  assign out_de   = r_de;
  assign locked   = (r_state == ST_LOCKED);
  assign offset   = r_offset;

endmodule

// File: tb/tb_tmds_rx_align_decode.sv
// Randomised and directed bench for tmds_rx_align_decode against a bit-level
// behavioural model of alignment search, lock watchdog and TMDS decode.
module tb_tmds_rx_align_decode;

  localparam int LOCK_RUN      = 16;
  localparam int SEARCH_CYCLES = 1024;
  localparam int LOSS_CYCLES   = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] in_sym;
  logic [7:0] out_data;
  logic [1:0] out_ctrl;
  logic       out_de;
  logic       locked;
  logic [3:0] offset;

  tmds_rx_align_decode #(
    .LOCK_RUN     (LOCK_RUN),
    .SEARCH_CYCLES(SEARCH_CYCLES),
    .LOSS_CYCLES  (LOSS_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_sym  (in_sym),
    .out_data(out_data),
    .out_ctrl(out_ctrl),
    .out_de  (out_de),
    .locked  (locked),
    .offset  (offset)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [9:0] m_prev;
  int         m_off, m_timer, m_run;
  bit         m_locked;
  logic [7:0] m_data;
  logic [1:0] m_ctrl;
  bit         m_de;

  function automatic bit ctrl_lookup(input logic [9:0] s, output logic [1:0] code);
    logic [9:0] table_syms [4];
    table_syms = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    code = 2'b00;
    for (int k = 0; k < 4; k++)
      if (s == table_syms[k]) begin
        code = 2'(k);
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic logic [7:0] decode_data(input logic [9:0] s);
    logic [7:0] q, d;
    q = s[7:0];
    if (s[9]) q = ~q;
    d[0] = q[0];
    for (int i = 1; i < 8; i++)
      d[i] = (q[i] ^ q[i-1]) ^ ~s[8];
    return d;
  endfunction

  // Earliest bits sit in the previous word; pick ten consecutive bits from 'off'.
  function automatic logic [9:0] pick_symbol(input logic [9:0] prev, input logic [9:0] cur, input int off);
    logic [9:0] s;
    for (int b = 0; b < 10; b++) begin
      int p = off + b;
      s[b] = (p < 10) ? prev[p] : cur[p-10];
    end
    return s;
  endfunction

  task automatic model_step(input bit r, input logic [9:0] sym);
    logic [9:0] s;
    logic [1:0] code;
    bit         is_ctrl, full_run, run_done;
    int         run_after;
    if (r) begin
      m_prev = '0; m_off = 0; m_timer = 0; m_run = 0; m_locked = 0;
      m_data = '0; m_ctrl = '0; m_de = 0;
      return;
    end
    s         = pick_symbol(m_prev, sym, m_off);
    is_ctrl   = ctrl_lookup(s, code);
    run_after = is_ctrl ? ((m_run + 1 > LOCK_RUN) ? LOCK_RUN : m_run + 1) : 0;
    run_done  = is_ctrl && (m_run + 1 == LOCK_RUN);
    full_run  = (m_run == LOCK_RUN);
    if (!m_locked) begin
      if (run_done) begin
        m_locked = 1; m_timer = 0; m_run = run_after;
      end else if (m_timer == SEARCH_CYCLES - 1) begin
        m_off = (m_off + 1) % 10; m_timer = 0; m_run = 0;
      end else begin
        m_timer++; m_run = run_after;
      end
    end else begin
      if (run_done || full_run) begin
        m_timer = 0; m_run = run_after;
      end else if (m_timer == LOSS_CYCLES - 1) begin
        m_locked = 0; m_timer = 0; m_run = 0;
      end else begin
        m_timer++; m_run = run_after;
      end
    end
    if (!m_locked) begin
      m_de = 0; m_data = '0; m_ctrl = '0;
    end else if (is_ctrl) begin
      m_de = 0; m_data = '0; m_ctrl = code;
    end else begin
      m_de = 1; m_data = decode_data(s);
    end
    m_prev = sym;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycle(input bit r, input logic [9:0] sym);
    @(negedge clk);
    rst    = r;
    in_sym = sym;
    model_step(r, sym);
    @(posedge clk);
    #1;
    check("outs", 32'({out_data, out_ctrl, out_de, locked, offset}),
          32'({m_data, m_ctrl, m_de, m_locked, 4'(m_off)}));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 10'($urandom));
  endtask

  function automatic logic [9:0] rand_data_sym();
    logic [9:0] s;
    logic [1:0] c;
    do s = 10'($urandom_range(0, 1023)); while (ctrl_lookup(s, c));
    return s;
  endfunction

  // Serial stream delivered 'sh' bits late: the word starts sh bits into the previous symbol.
  function automatic logic [9:0] late_word(input logic [9:0] cur, input logic [9:0] prev, input int sh);
    logic [19:0] stream;
    stream = {cur, prev} >> (10 - sh);
    return stream[9:0];
  endfunction

  initial begin
    logic [9:0] sym_prev, sym_cur, sym;
    logic [1:0] burst_code;
    int         k, lock_seen, burst_left;
    bit         burst_ctrl;
    rst    = 1'b1;
    in_sym = '0;

    // Reset: held three cycles with random input, then one released cycle.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 10'($urandom));
      check("rst_hold", 32'({out_data, out_ctrl, out_de, locked, offset}), 32'd0);
    end
    cycle(1'b0, 10'h100);
    check("rst_release", 32'({out_data, out_ctrl, out_de, locked, offset}), 32'd0);

    // Aligned lock on 0x354: the 16th control symbol reaches the window on edge 17.
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 10'h354);
      if (i == 16) check("lock_early", 32'(locked), 32'd0);
      if (i == 17) begin
        check("lock_rise", 32'(locked), 32'd1);
        check("lock_ctrl", 32'({out_ctrl, out_de, offset}), 32'({2'b00, 1'b0, 4'd0}));
      end
    end
    cycle(1'b0, 10'h100); cycle(1'b0, 10'h100);
    check("data_100", 32'({out_de, out_data}), 32'({1'b1, 8'h00}));
    cycle(1'b0, 10'h2FF); cycle(1'b0, 10'h2FF);
    check("data_2ff", 32'({out_de, out_data}), 32'({1'b1, 8'hFE}));
    cycle(1'b0, 10'h0AB); cycle(1'b0, 10'h0AB);
    check("ctrl_0ab", 32'({out_de, out_ctrl}), 32'({1'b0, 2'b01}));

    // Runs one symbol short of LOCK_RUN never lock.
    do_reset(1);
    for (int i = 0; i < 900; i++) cycle(1'b0, (i % 16 == 15) ? 10'h100 : 10'h154);
    check("short_run", 32'({locked, offset}), 32'd0);

    // Stream delayed by 3 bits: three slips then lock at offset 3.
    do_reset(1);
    sym_prev  = '0;
    lock_seen = 0;
    k         = 0;
    while (k < 3 * SEARCH_CYCLES + LOCK_RUN + 64 && !lock_seen) begin
      sym_cur = ((k % 72) < 64) ? 10'h154 : rand_data_sym();
      cycle(1'b0, late_word(sym_cur, sym_prev, 3));
      sym_prev = sym_cur;
      k++;
      if (k == 1023) check("slip_before", 32'(offset), 32'd0);
      if (k == 1024) check("slip_1", 32'(offset), 32'd1);
      if (k == 2048) check("slip_2", 32'(offset), 32'd2);
      if (k == 3072) check("slip_3", 32'(offset), 32'd3);
      if (locked) begin
        lock_seen = 1;
        check("late_lock_ctrl", 32'({offset, out_ctrl, out_de}), 32'({4'd3, 2'b10, 1'b0}));
      end
    end
    check("late_lock", 32'(lock_seen), 32'd1);

    // Data only: offset steps 0..9 and wraps, never locking.
    do_reset(1);
    for (int i = 1; i <= 10 * SEARCH_CYCLES; i++) begin
      cycle(1'b0, 10'h100);
      if (i % SEARCH_CYCLES == 0) check("wrap_offset", 32'(offset), 32'((i / SEARCH_CYCLES) % 10));
    end
    check("wrap_unlocked", 32'(locked), 32'd0);

    // Loss: watchdog last cleared on edge 22, lock drops exactly LOSS_CYCLES later.
    do_reset(1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 10'h354);
    check("loss_locked", 32'(locked), 32'd1);
    for (int i = 1; i <= 4100; i++) begin
      cycle(1'b0, 10'h100);
      if (i == 4097) check("loss_hold", 32'(locked), 32'd1);
      if (i == 4098) check("loss_drop", 32'({locked, offset}), 32'd0);
    end

    // Reset mid-data while locked.
    do_reset(1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 10'h354);
    for (int i = 0; i < 5; i++) cycle(1'b0, 10'h2FF);
    check("pre_rst_locked", 32'({locked, out_de}), 32'd3);
    cycle(1'b1, 10'h2FF);
    check("mid_rst", 32'({out_data, out_ctrl, out_de, locked, offset}), 32'd0);
    cycle(1'b0, 10'h354);
    check("post_rst_search", 32'({locked, out_ctrl, out_de}), 32'd0);

    // Random control/data bursts at zero skew.
    do_reset(2);
    burst_left = 0;
    burst_ctrl = 0;
    burst_code = 2'b00;
    for (int i = 0; i < 4000; i++) begin
      if (burst_left == 0) begin
        burst_ctrl = ($urandom_range(0, 2) != 0);
        burst_left = burst_ctrl ? $urandom_range(8, 40) : $urandom_range(1, 6);
        burst_code = 2'($urandom_range(0, 3));
      end
      case (burst_code)
        2'd0:    sym = 10'h354;
        2'd1:    sym = 10'h0AB;
        2'd2:    sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
      if (!burst_ctrl) sym = rand_data_sym();
      cycle(1'b0, sym);
      burst_left--;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
